// File: rtl/sort_hw_mem_pkg.sv
// Shared types and constants for the sort_hw dual-port RAM slice.
package sort_hw_mem_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sort_hw_ram_dp_if.sv
// One Avalon-MM slave port of the dual-port RAM.
interface sort_hw_ram_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  import sort_hw_mem_pkg::*;

  localparam int BE_WIDTH = byte_lanes(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] address;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [BE_WIDTH-1:0]   byteenable;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/sort_hw_ram_dp_port.sv
// Per-port accept decode, range check and stallable read-return pipeline.
module sort_hw_ram_dp_port
  import sort_hw_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_en,
  input  logic                  blocked,
  sort_hw_ram_dp_if.slave       bus,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wr_en
);

  localparam int LAT = (READ_LATENCY >= READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY_MIN;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  logic                  req;
  logic                  rd_en;
  logic                  in_range;
  logic [LAT-1:0]        vld_q;
  logic [DATA_WIDTH-1:0] dat_q [LAT];

  assign bus.waitrequest = blocked;
  assign req      = bus.chipselect & (bus.read | bus.write) & ~blocked;
  assign in_range = ({1'b0, bus.address} < DEPTH_LIM);
  assign wr_en    = req & bus.write & in_range;
  // read+write together is a write only, so it never produces a beat
  assign rd_en    = req & bus.read & ~bus.write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else if (pipe_en) begin
      vld_q[0] <= rd_en;
      if (rd_en) dat_q[0] <= in_range ? mem_rdata : '0;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.readdata      = dat_q[LAT-1];
  assign bus.readdatavalid = vld_q[LAT-1];

endmodule

// File: rtl/sort_hw_ram_dp.sv
// True dual-port RAM with two Avalon-MM slaves and a hardware zero-fill engine.
module sort_hw_ram_dp
  import sort_hw_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reset_req,
  input  logic            clken,
  input  logic            clear,
  output logic            clear_busy,
  sort_hw_ram_dp_if.slave s1,
  sort_hw_ram_dp_if.slave s2
);

  localparam int LANES = byte_lanes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  enable;
  logic                  blocked;
  logic                  fill_we;
  logic                  s1_we, s2_we, s2_keep;
  logic [DATA_WIDTH-1:0] s1_rdata, s2_rdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign enable     = clken & ~reset_req;
  assign blocked    = (state_q == CLEAR) | ~clken | reset_req | reset;
  assign clear_busy = (state_q == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // fill advances one word per enabled cycle; clear pulses only matter in RUN
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    fill_we   = 1'b0;
    case (state_q)
      CLEAR: begin
        if (enable) begin
          fill_we = 1'b1;
          if (clr_cnt_q == LAST_WORD) begin
            state_d   = RUN;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  sort_hw_ram_dp_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH), .READ_LATENCY(READ_LATENCY)
  ) u_port1 (
    .clk(clk), .reset(reset), .pipe_en(clken), .blocked(blocked),
    .bus(s1), .mem_rdata(s1_rdata), .wr_en(s1_we)
  );

  sort_hw_ram_dp_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH), .READ_LATENCY(READ_LATENCY)
  ) u_port2 (
    .clk(clk), .reset(reset), .pipe_en(clken), .blocked(blocked),
    .bus(s2), .mem_rdata(s2_rdata), .wr_en(s2_we)
  );

  // reads sample pre-edge contents, so a same-cycle write on the other port yields old data
  assign s1_rdata = mem[s1.address];
  assign s2_rdata = mem[s2.address];

  // same-address write collision: s1 owns the whole word, s2 is dropped
  assign s2_keep = s2_we & ~(s1_we & (s1.address == s2.address));

  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int b = 0; b < LANES; b++) begin
        if (s1_we && s1.byteenable[b]) mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
        if (s2_keep && s2.byteenable[b]) mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
      end
    end
  end

endmodule
